channelizer2: RTL and testbench
===============================

// Module: channelizer2
// PURPOSE
// Avalon-ST sink that reassembles 2-word packets into one parallel channel pair.
// Word 1 (SOP) goes to channel 1 and word 2 (EOP) goes to channel 2.
// The pair is presented with a valid/ready handshake to the downstream stage.
// Sits on the receive side of the serial I/Q link, as the inverse of the 2-channel dechannelizer.
// Malformed framing is discarded and counted.
// PARAMETERS
// WIDTH   24  sample width of each channel word
// ERR_W   16  width of the saturating framing-error counter
// PORTS
// clk         in   1      system clock, all logic on rising edge
// rst_n       in   1      synchronous reset, active low
// in_data     in   WIDTH  serial sample word
// in_valid    in   1      in_data valid
// in_sop      in   1      start of packet (channel 1 word)
// in_eop      in   1      end of packet (channel 2 word)
// in_ready    out  1      sink ready; a word is accepted when in_valid && in_ready
// out_data_1  out  WIDTH  channel 1 sample
// out_data_2  out  WIDTH  channel 2 sample
// out_valid   out  1      channel pair valid
// out_ready   in   1      downstream accepts the pair when out_valid && out_ready
// err_clr     in   1      one-cycle pulse: clears err_count and err_flag
// err_count   out  ERR_W  framing errors, saturates at all-ones
// err_flag    out  1      sticky: set on any framing error
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - state=IDLE; out_data_1/2=0, out_valid=0, err_count=0, err_flag=0.
//   - A reset mid-packet discards the partial pair; a held pair is lost.
// - in_ready is combinational:
//   - 1 in IDLE, CH2 and DROP.
//   - In HOLD, in_ready = out_ready.
// - "acc" means in_valid && in_ready. "err" means err_count+1 (saturating) and err_flag=1.
// - State machine (registered):
//   - IDLE, acc with sop&!eop: out_data_1<=in_data, go to CH2.
//   - IDLE, acc with sop&eop, or !sop: word dropped, err, stay IDLE.
//   - CH2, acc with eop&!sop: out_data_2<=in_data, out_valid<=1, go to HOLD.
//     Pair is visible the cycle after the EOP word is accepted (latency 1).
//   - CH2, acc with sop (eop or not): restart. out_data_1<=in_data, err, stay CH2.
//     If sop&eop: drop the word, err, go to IDLE.
//   - CH2, acc with !sop&!eop: packet too long. Drop, err, go to DROP.
//   - DROP: accept and discard words. SOP-only word: capture as channel 1, go to CH2.
//     Word with eop: go to IDLE. No further errors are counted in DROP.
//   - HOLD: out_data_1/2 stable, out_valid=1 until out_ready.
//     - If out_ready: out_valid<=0 next cycle, and a word accepted the same cycle follows the IDLE rules.
//     - So back-to-back packets run at 2 words per 2 cycles.
//   - While out_valid=0, out_data_1 may change (on SOP capture); out_data_2 holds its last value.
// - err_clr:
//   - err_clr has priority over a same-cycle increment: both clear and flag end at 0.
//   - Counter holds at 2^ERR_W-1 and never wraps.
// - No arithmetic on data; words are passed through bit-exact.
// - in_valid=0 never changes state.
// TESTING
// - Reset, then SOP 0x123456 and EOP 0xABCDEF on consecutive cycles, out_ready=1:
//   out_valid=1 for exactly 1 cycle, 2 cycles after SOP, with out_data_1=0x123456 and out_data_2=0xABCDEF.
// - out_ready=0 for 5 cycles after a pair:
//   out_valid held, in_ready=0, data stable. Raise out_ready with the next SOP present:
//   SOP accepted that cycle, out_valid drops next cycle.
// - Orphan EOP in IDLE, then a valid pair:
//   orphan dropped, err_count=1, err_flag=1, valid pair delivered correctly.
// - SOP 0x000001, SOP 0x000002, EOP 0x000003:
//   out_data_1=0x000002, out_data_2=0x000003, err_count=1.
// - SOP, mid word (no flags), mid word, EOP, then a good pair:
//   one err, no output for the first packet, second pair delivered.
//   Then err_clr with a same-cycle error: count=0, flag=0.
// - rst_n=0 for 1 cycle in CH2 and in HOLD:
//   out_valid=0, state IDLE, err_count=0. Force err_count to max and inject an error: count stays at max.

Source files
------------

// File: rtl/channelizer2.sv
// Avalon-ST sink that reassembles SOP/EOP word pairs into a parallel channel pair.
// Malformed framing is discarded and tallied in a saturating error counter.
module channelizer2 #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data_1,
  output logic [WIDTH-1:0] out_data_2,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_count,
  output logic             err_flag
);

  typedef enum logic [1:0] {IDLE, CH2, HOLD, DROP} state_t;

  state_t state;
  logic   acc;
  logic   sop_only;
  logic   eop_only;
  logic   err_hit;

  // Only a held pair that downstream has not taken can stall the sink
  always_comb begin
    in_ready = 1'b1;
    if (state == HOLD) in_ready = out_ready;
  end

  assign acc      = in_valid && in_ready;
  assign sop_only = in_sop && !in_eop;
  assign eop_only = in_eop && !in_sop;

  // Framing error decode; HOLD with a handshake behaves like IDLE
  always_comb begin
    err_hit = 1'b0;
    case (state)
      IDLE:    err_hit = acc && !sop_only;
      HOLD:    err_hit = acc && !sop_only;
      CH2:     err_hit = acc && !eop_only;
      default: err_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_data_1 <= '0;
      out_data_2 <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && sop_only) begin
            out_data_1 <= in_data;
            state      <= CH2;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            if (acc && sop_only) begin
              out_data_1 <= in_data;
              state      <= CH2;
            end
          end
        end
        CH2: begin
          if (acc) begin
            if (eop_only) begin
              out_data_2 <= in_data;
              out_valid  <= 1'b1;
              state      <= HOLD;
            end else if (sop_only) begin
              out_data_1 <= in_data;
            end else if (in_sop) begin
              state <= IDLE;
            end else begin
              state <= DROP;
            end
          end
        end
        DROP: begin
          if (acc) begin
            if (sop_only) begin
              out_data_1 <= in_data;
              state      <= CH2;
            end else if (in_eop) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear wins over a same-cycle error; the counter sticks at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
      err_flag  <= 1'b0;
    end else if (err_clr) begin
      err_count <= '0;
      err_flag  <= 1'b0;
    end else if (err_hit) begin
      err_flag <= 1'b1;
      if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_channelizer2.sv
// Directed bench for channelizer2: stimulus pushes expected pairs, a monitor pops
// and compares them on every output handshake.
module tb_channelizer2;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned ERR_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sop;
  logic             in_eop;
  logic             in_ready;
  logic [WIDTH-1:0] out_data_1;
  logic [WIDTH-1:0] out_data_2;
  logic             out_valid;
  logic             out_ready;
  logic             err_clr;
  logic [ERR_W-1:0] err_count;
  logic             err_flag;

  int checks = 0;
  int errors = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  channelizer2 #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .out_data_1(out_data_1), .out_data_2(out_data_2), .out_valid(out_valid),
    .out_ready(out_ready),
    .err_clr(err_clr), .err_count(err_count), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted output pair must match the queue head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pair_unexpected got %h_%h expected none", out_data_1, out_data_2);
      end else begin
        logic [2*WIDTH-1:0] e;
        e = exp_q.pop_front();
        if ({out_data_1, out_data_2} !== e) begin
          errors++;
          $display("FAIL pair_data got %h_%h expected %h", out_data_1, out_data_2, e);
        end
      end
    end
  end

  // Present one word from posedge+1 and hold it until accepted (bounded)
  task automatic word(input logic [WIDTH-1:0] d, input logic s, input logic e);
    int n = 0;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL word_timeout got in_ready=%b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_q.push_back({a, b});
    word(a, 1'b1, 1'b0);
    word(b, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data1", 64'(out_data_1), 64'd0);
    chk("rst_data2", 64'(out_data_2), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_err_flag", 64'(err_flag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Basic pair, latency 1 after EOP, one-cycle valid
    pair(24'h123456, 24'hABCDEF);
    @(negedge clk);
    chk("t1_valid_on", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("t1_valid_off", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Backpressure: pair held, sink stalled, SOP taken on release
    out_ready = 1'b0;
    pair(24'h0A0B0C, 24'h0D0E0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", 64'(out_valid), 64'd1);
      chk("t2_hold_ready", 64'(in_ready), 64'd0);
      chk("t2_hold_data", 64'({out_data_1, out_data_2}), 64'({24'h0A0B0C, 24'h0D0E0F}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back({24'h222222, 24'h333333});
    word(24'h222222, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_valid_drop", 64'(out_valid), 64'd0);
    chk("t2_no_err", 64'(err_count), 64'd0);
    @(posedge clk); #1;
    word(24'h333333, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2_second_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // Orphan EOP in IDLE, then a good pair
    word(24'h999999, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_err_count", 64'(err_count), 64'd1);
    chk("t3_err_flag", 64'(err_flag), 64'd1);
    chk("t3_no_output", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    pair(24'h445566, 24'h778899);
    @(posedge clk); #1;

    // Restart on a second SOP
    clr();
    exp_q.push_back({24'h000002, 24'h000003});
    word(24'h000001, 1'b1, 1'b0);
    word(24'h000002, 1'b1, 1'b0);
    word(24'h000003, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_err_count", 64'(err_count), 64'd1);
    @(posedge clk); #1;

    // Overlong packet dropped with a single error, next pair delivered
    clr();
    word(24'h100000, 1'b1, 1'b0);
    word(24'h200000, 1'b0, 1'b0);
    word(24'h300000, 1'b0, 1'b0);
    word(24'h400000, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5_no_output", 64'(out_valid), 64'd0);
    chk("t5_err_count", 64'(err_count), 64'd1);
    @(posedge clk); #1;
    pair(24'h5A5A5A, 24'hA5A5A5);
    @(negedge clk);
    chk("t5_pair_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    word(24'hEEEEEE, 1'b0, 1'b1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr_count", 64'(err_count), 64'd0);
    chk("t5_clr_flag", 64'(err_flag), 64'd0);
    @(posedge clk); #1;

    // Reset in CH2 discards the partial packet
    word(24'hEEEEEE, 1'b0, 1'b1);
    word(24'h111111, 1'b1, 1'b0);
    do_reset();
    @(negedge clk);
    chk("t6_ch2_valid", 64'(out_valid), 64'd0);
    chk("t6_ch2_count", 64'(err_count), 64'd0);
    chk("t6_ch2_flag", 64'(err_flag), 64'd0);
    @(posedge clk); #1;
    word(24'h121212, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_idle_orphan", 64'(err_count), 64'd1);
    chk("t6_idle_novalid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Reset in HOLD loses the held pair
    out_ready = 1'b0;
    word(24'h131313, 1'b1, 1'b0);
    word(24'h141414, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_hold_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("t6_hold_cleared", 64'(out_valid), 64'd0);
    chk("t6_hold_data", 64'({out_data_1, out_data_2}), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Saturation of the error counter
    for (int i = 0; i < 15; i++) word(24'h00F00F, 1'b0, 1'b1);
    @(negedge clk);
    chk("t7_at_max", 64'(err_count), 64'd15);
    @(posedge clk); #1;
    word(24'h00F00F, 1'b1, 1'b1);
    @(negedge clk);
    chk("t7_saturated", 64'(err_count), 64'd15);
    chk("t7_flag", 64'(err_flag), 64'd1);
    @(posedge clk); #1;

    pair(24'hFEDCBA, 24'h012345);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
